// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared defaults, state encoding and lane vector type for the skew feeder
package systolic_pkg;
    localparam int FEED_DW    = 32;
    localparam int FEED_DIM   = 5;
    localparam int FEED_K_MAX = 16;
    localparam int DRAIN_CYC  = FEED_DIM;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STREAM,
        ST_DRAIN,
        ST_STORE
    } feed_state_e;

    typedef logic [FEED_DIM*FEED_DW-1:0] lane_vec_t;
endpackage

// File: rtl/feeder_buf.sv
// rtl/feeder_buf.sv - job operand store: one write port, DIM per-lane read ports (bank select with FEEDER_DBUF_EN)
module feeder_buf
    import systolic_pkg::*;
#(
    parameter int DW    = FEED_DW,
    parameter int DIM   = FEED_DIM,
    parameter int K_MAX = FEED_K_MAX,
    parameter int KW    = $clog2(K_MAX)
) (
    input  logic                clk,
    input  logic                wr_en,
`ifdef FEEDER_DBUF_EN
    input  logic                wr_bank,
    input  logic                rd_bank,
`endif
    input  logic [KW-1:0]       wr_addr,
    input  logic [DIM*DW-1:0]   wr_a,
    input  logic [DIM*DW-1:0]   wr_b,
    input  logic [DIM*KW-1:0]   rd_addr,
    output logic [DIM*DW-1:0]   rd_a,
    output logic [DIM*DW-1:0]   rd_b
);
`ifdef FEEDER_DBUF_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif
    localparam int IW = $clog2(NB*K_MAX);

    logic [DIM*DW-1:0] mem_a_q [NB*K_MAX];
    logic [DIM*DW-1:0] mem_b_q [NB*K_MAX];
    logic [IW-1:0]     wr_idx;
    logic [IW-1:0]     rd_idx [DIM];

    always_comb begin
`ifdef FEEDER_DBUF_EN
        wr_idx = {wr_bank, wr_addr};
        for (int i = 0; i < DIM; i++) rd_idx[i] = {rd_bank, rd_addr[i*KW +: KW]};
`else
        wr_idx = wr_addr;
        for (int i = 0; i < DIM; i++) rd_idx[i] = rd_addr[i*KW +: KW];
`endif
    end

    // Storage is deliberately not reset; contents are only read after a full load.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_a_q[wr_idx] <= wr_a;
            mem_b_q[wr_idx] <= wr_b;
        end
    end

    always_comb begin
        rd_a = '0;
        rd_b = '0;
        for (int i = 0; i < DIM; i++) begin
            rd_a[i*DW +: DW] = mem_a_q[rd_idx[i]][i*DW +: DW];
            rd_b[i*DW +: DW] = mem_b_q[rd_idx[i]][i*DW +: DW];
        end
    end
endmodule

// File: rtl/systolic_skew_feeder.sv
// rtl/systolic_skew_feeder.sv - buffers one K-beat job and replays it diagonally skewed into the array
// Optional macro FEEDER_DBUF_EN: two banks, loading overlaps streaming, back-to-back jobs.
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int DW    = FEED_DW,
    parameter int DIM   = FEED_DIM,
    parameter int K_MAX = FEED_K_MAX
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic                ld_last,
    input  logic [DIM*DW-1:0]   ld_a,
    input  logic [DIM*DW-1:0]   ld_b,
    output logic [DIM*DW-1:0]   a_out,
    output logic [DIM*DW-1:0]   b_out,
    output logic                clr,
    output logic                st,
    output logic                busy,
    output logic                done
);
    localparam int CW = $clog2(K_MAX + DIM);
    localparam int KW = $clog2(K_MAX);

    feed_state_e       state_q, state_d;
    logic [CW-1:0]     t_q, t_d, k_q, k_d, wptr_q, wptr_d;
    logic [DIM*DW-1:0] a_out_q, a_out_d, b_out_q, b_out_d;
    logic              clr_q, clr_d, st_q, st_d, busy_q, busy_d, done_q, done_d;
    logic              accept, complete;
    logic [CW-1:0]     rel [DIM];
    logic [DIM-1:0]    lane_live;
    logic [DIM*KW-1:0] rd_addr;
    logic [DIM*DW-1:0] rd_a, rd_b;

`ifdef FEEDER_DBUF_EN
    logic          wbank_q, wbank_d, rbank_q, rbank_d;
    logic [1:0]    full_q, full_d;
    logic [CW-1:0] klen_q [2];
    logic [CW-1:0] klen_d [2];

    assign ld_ready = rst_n && !full_q[wbank_q];
`else
    assign ld_ready = rst_n && (state_q == ST_IDLE);
`endif
    assign accept   = ld_valid && ld_ready;
    assign complete = accept && (ld_last || wptr_q == CW'(K_MAX - 1));

    feeder_buf #(.DW(DW), .DIM(DIM), .K_MAX(K_MAX), .KW(KW)) u_buf (
        .clk     (clk),
        .wr_en   (accept),
`ifdef FEEDER_DBUF_EN
        .wr_bank (wbank_q),
        .rd_bank (rbank_q),
`endif
        .wr_addr (wptr_q[KW-1:0]),
        .wr_a    (ld_a),
        .wr_b    (ld_b),
        .rd_addr (rd_addr),
        .rd_a    (rd_a),
        .rd_b    (rd_b)
    );

    // Lane i replays beat t-i; it is silent before its first and after its last beat.
    always_comb begin
        rd_addr   = '0;
        lane_live = '0;
        for (int i = 0; i < DIM; i++) begin
            rel[i]                = t_q - CW'(i);
            lane_live[i]          = (t_q >= CW'(i)) && (rel[i] < k_q);
            rd_addr[i*KW +: KW]   = rel[i][KW-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        k_d     = k_q;
        wptr_d  = wptr_q;
        a_out_d = '0;
        b_out_d = '0;
        clr_d   = 1'b0;
        st_d    = 1'b0;
        done_d  = 1'b0;
        busy_d  = 1'b1;
`ifdef FEEDER_DBUF_EN
        full_d  = full_q;
        klen_d  = klen_q;
        wbank_d = wbank_q;
        rbank_d = rbank_q;
        if (complete) begin
            full_d[wbank_q] = 1'b1;
            klen_d[wbank_q] = wptr_q + CW'(1);
            wbank_d         = ~wbank_q;
        end
`endif
        if (accept) wptr_d = complete ? '0 : wptr_q + CW'(1);

        unique case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
`ifdef FEEDER_DBUF_EN
                if (full_d[rbank_q]) begin
                    k_d     = klen_d[rbank_q];
                    state_d = ST_CLEAR;
                end
`else
                if (complete) begin
                    k_d     = wptr_q + CW'(1);
                    state_d = ST_CLEAR;
                end
`endif
            end
            ST_CLEAR: begin
                clr_d   = 1'b1;
                t_d     = '0;
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                for (int i = 0; i < DIM; i++) begin
                    if (lane_live[i]) begin
                        a_out_d[i*DW +: DW] = rd_a[i*DW +: DW];
                        b_out_d[i*DW +: DW] = rd_b[i*DW +: DW];
                    end
                end
                t_d = t_q + CW'(1);
                if (t_q == k_q + CW'(DIM - 2)) begin
                    t_d     = '0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                t_d = t_q + CW'(1);
                if (t_q == CW'(DRAIN_CYC - 1)) begin
                    t_d     = '0;
                    state_d = ST_STORE;
                end
            end
            ST_STORE: begin
                st_d    = 1'b1;
                done_d  = 1'b1;
                state_d = ST_IDLE;
`ifdef FEEDER_DBUF_EN
                full_d[rbank_q] = 1'b0;
                rbank_d         = ~rbank_q;
                if (full_d[~rbank_q]) begin
                    k_d     = klen_d[~rbank_q];
                    state_d = ST_CLEAR;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
            k_q     <= '0;
            wptr_q  <= '0;
            a_out_q <= '0;
            b_out_q <= '0;
            clr_q   <= 1'b0;
            st_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef FEEDER_DBUF_EN
            wbank_q <= 1'b0;
            rbank_q <= 1'b0;
            full_q  <= '0;
            klen_q  <= '{default: '0};
`endif
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            k_q     <= k_d;
            wptr_q  <= wptr_d;
            a_out_q <= a_out_d;
            b_out_q <= b_out_d;
            clr_q   <= clr_d;
            st_q    <= st_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef FEEDER_DBUF_EN
            wbank_q <= wbank_d;
            rbank_q <= rbank_d;
            full_q  <= full_d;
            klen_q  <= klen_d;
`endif
        end
    end

    assign a_out = a_out_q;
    assign b_out = b_out_q;
    assign clr   = clr_q;
    assign st    = st_q;
    assign busy  = busy_q;
    assign done  = done_q;
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb/tb_systolic_skew_feeder.sv - self-checking bench for systolic_skew_feeder
module tb_systolic_skew_feeder;
    import systolic_pkg::*;

    localparam int DW  = FEED_DW;
    localparam int DIM = FEED_DIM;
    localparam int KM  = FEED_K_MAX;

    logic      clk = 1'b0;
    logic      rst_n = 1'b0;
    logic      ld_valid = 1'b0;
    logic      ld_last = 1'b0;
    lane_vec_t ld_a = '0;
    lane_vec_t ld_b = '0;
    logic      ld_ready, clr, st, busy, done;
    lane_vec_t a_out, b_out;

    int total = 0;
    int bad = 0;

    int unsigned am [DIM][KM];
    int unsigned bm [KM][DIM];
    int unsigned ahist [64][DIM];
    int unsigned bhist [64][DIM];

    always #5 clk = ~clk;

    systolic_skew_feeder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_last  (ld_last),
        .ld_a     (ld_a),
        .ld_b     (ld_b),
        .a_out    (a_out),
        .b_out    (b_out),
        .clr      (clr),
        .st       (st),
        .busy     (busy),
        .done     (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_v(input string tag, input lane_vec_t obs, input lane_vec_t exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // mode 0: identity, 1: lane number + 1, 2: random
    task automatic gen_job(input int mode);
        for (int i = 0; i < DIM; i++) begin
            for (int k = 0; k < KM; k++) begin
                am[i][k] = (mode == 0) ? ((i == k) ? 1 : 0) : (mode == 1) ? i + 1 : $urandom;
                bm[k][i] = (mode == 0) ? ((i == k) ? 1 : 0) : (mode == 1) ? i + 1 : $urandom;
            end
        end
    endtask

    // Lane i carries beat c-1-i at c cycles after clr.
    function automatic lane_vec_t exp_lanes(input bit is_b, input int c, input int k);
        lane_vec_t v = '0;
        for (int i = 0; i < DIM; i++) begin
            int idx = c - 1 - i;
            if (idx >= 0 && idx < k) v[i*DW +: DW] = is_b ? bm[idx][i] : am[i][idx];
        end
        return v;
    endfunction

    task automatic load_job(input int k, input bit use_last);
        for (int b = 0; b < k; b++) begin
            @(negedge clk);
            chk("ld_ready_load", ld_ready, 1);
            ld_valid = 1'b1;
            ld_last  = use_last && (b == k - 1);
            for (int i = 0; i < DIM; i++) begin
                ld_a[i*DW +: DW] = am[i][b];
                ld_b[i*DW +: DW] = bm[b][i];
            end
        end
        @(negedge clk);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        chk("ld_ready_drop", ld_ready, 0);
    endtask

    task automatic wait_clr();
        int lat = 0;
        while (clr !== 1'b1 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk("clr_latency", lat, 1);
    endtask

    // Plays the array: PE(i,j) sees A lane i delayed j cycles and B lane j delayed i cycles.
    task automatic run_job(input int k, input bit hold);
        int st_c = k + DIM + DRAIN_CYC;
        logic [DIM*DIM*DW-1:0] cref, cdut;
        logic [DW-1:0] sr, sd;
        wait_clr();
        chk("busy_t0", busy, 1);
        chk_v("a_out_t0", a_out, '0);
        for (int i = 0; i < DIM; i++) begin
            ahist[0][i] = a_out[i*DW +: DW];
            bhist[0][i] = b_out[i*DW +: DW];
        end
        if (hold) begin
            ld_valid = 1'b1;
            ld_last  = 1'b1;
            ld_a     = {$urandom, $urandom, $urandom, $urandom, $urandom};
            ld_b     = {$urandom, $urandom, $urandom, $urandom, $urandom};
        end
        for (int c = 1; c <= st_c + 1; c++) begin
            @(negedge clk);
            if (c <= st_c) begin
                chk_v("a_out", a_out, exp_lanes(1'b0, c, k));
                chk_v("b_out", b_out, exp_lanes(1'b1, c, k));
                chk("st", st, (c == st_c) ? 1 : 0);
                chk("done", done, (c == st_c) ? 1 : 0);
                chk("clr_low", clr, 0);
                chk("busy", busy, 1);
                if (hold && c < st_c) chk("ld_ready_busy", ld_ready, 0);
                if (hold && c == st_c) begin
                    ld_valid = 1'b0;
                    ld_last  = 1'b0;
                end
                for (int i = 0; i < DIM; i++) begin
                    ahist[c][i] = a_out[i*DW +: DW];
                    bhist[c][i] = b_out[i*DW +: DW];
                end
            end else begin
                chk("busy_after", busy, 0);
                chk("st_after", st, 0);
                chk("ld_ready_after", ld_ready, 1);
            end
        end
        cref = '0;
        cdut = '0;
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                sr = '0;
                sd = '0;
                for (int kk = 0; kk < k; kk++) sr += DW'(am[i][kk] * bm[kk][j]);
                for (int c = 0; c <= st_c; c++) begin
                    if (c - j >= 0 && c - i >= 0) sd += DW'(ahist[c-j][i] * bhist[c-i][j]);
                end
                cref[(i*DIM+j)*DW +: DW] = sr;
                cdut[(i*DIM+j)*DW +: DW] = sd;
            end
        end
        total++;
        assert (cdut === cref) else begin
            bad++;
            $error("FAIL matrix obs=%h exp=%h", cdut, cref);
        end
    endtask

    initial begin
        int k;
        repeat (3) @(negedge clk);
        chk_v("rst_a_out", a_out, '0);
        chk_v("rst_b_out", b_out, '0);
        chk("rst_busy", busy, 0);
        chk("rst_clr", clr, 0);
        chk("rst_st", st, 0);
        chk("rst_ld_ready", ld_ready, 0);
        rst_n = 1'b1;
        #1;
        chk("ld_ready_idle", ld_ready, 1);

        gen_job(0);
        load_job(5, 1'b1);
        run_job(5, 1'b0);

        gen_job(1);
        load_job(1, 1'b1);
        run_job(1, 1'b0);

        gen_job(2);
        load_job(KM, 1'b0);
        run_job(KM, 1'b0);

        k = $urandom_range(2, 9);
        gen_job(2);
        load_job(k, 1'b1);
        run_job(k, 1'b1);

        gen_job(2);
        load_job(3, 1'b1);
        run_job(3, 1'b0);

        gen_job(2);
        load_job(6, 1'b1);
        wait_clr();
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("ld_ready_in_rst", ld_ready, 0);
        @(negedge clk);
        chk_v("mid_rst_a_out", a_out, '0);
        chk_v("mid_rst_b_out", b_out, '0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_clr", clr, 0);
        chk("mid_rst_st", st, 0);
        chk("mid_rst_done", done, 0);
        rst_n = 1'b1;

        k = $urandom_range(1, KM);
        gen_job(2);
        load_job(k, 1'b1);
        run_job(k, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
